// File: rtl/eth_rx_frame_filter_if.sv
// eth_rx_frame_filter_if: byte-wide AXI-Stream style link with frame-error sideband.
interface eth_rx_frame_filter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: store-and-forward Ethernet receive filter; frames are released only after commit.
module eth_rx_frame_filter #(
  parameter int          DEPTH       = 2048,
  parameter int          MIN_LEN     = 60,
  parameter int          MAX_LEN     = 1514,
  parameter logic [47:0] MAC_ADDRESS = 48'h00_0A_35_00_00_01,
  parameter bit          PROMISCUOUS = 1'b0
) (
  input  logic                         clock,
  input  logic                         aresetn,
  eth_rx_frame_filter_if.slave         in_if,
  eth_rx_frame_filter_if.master        out_if,
  output logic [15:0]                  frames_accepted,
  output logic [15:0]                  frames_dropped
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_e;
  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [15:0] len_q, len_d, acc_q, acc_d, drop_q, drop_d, idx;
  logic        match_q, match_d, bcast_q, bcast_d;
  logic        full, we, hdr, ok, fetch, load, out_free, ram_vld_q, out_vld_q;
  logic [7:0]  mac_b;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  ram_q, out_q;
  assign in_if.tready    = 1'b1;
  assign full            = (wr_ptr_q - rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign frames_accepted = acc_q;
  assign frames_dropped  = drop_q;
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    match_d      = match_q;
    bcast_d      = bcast_q;
    acc_d        = acc_q;
    drop_d       = drop_q;
    we           = 1'b0;
    ok           = 1'b0;
    idx          = state_q == IDLE ? 16'd0 : len_q;
    hdr          = idx < 16'd6;
    mac_b        = 8'(MAC_ADDRESS >> (6'd40 - {idx[2:0], 3'b000}));
    if (in_if.tvalid && state_q != DISCARD) begin
      if (full) begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = drop_q + 16'd1;
        state_d  = in_if.tlast ? IDLE : DISCARD;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        len_d    = state_q == IDLE ? 16'd1 : (&len_q ? len_q : len_q + 16'd1);
        match_d  = (idx == 16'd0 || match_q) && (!hdr || in_if.tdata == mac_b);
        bcast_d  = (idx == 16'd0 || bcast_q) && (!hdr || in_if.tdata == 8'hFF);
        // Frames under 6 bytes never carry a full destination address
        ok       = !in_if.tuser && len_d >= 16'd6 && len_d >= 16'(MIN_LEN) &&
                   len_d <= 16'(MAX_LEN) && (match_d || bcast_d || PROMISCUOUS);
        state_d  = in_if.tlast ? IDLE : RECV;
        if (in_if.tlast) begin
          wr_ptr_d     = ok ? wr_ptr_q + 1'b1 : commit_ptr_q;
          commit_ptr_d = ok ? wr_ptr_q + 1'b1 : commit_ptr_q;
          acc_d        = ok ? acc_q + 16'd1 : acc_q;
          drop_d       = ok ? drop_q : drop_q + 16'd1;
        end
      end
    end else if (in_if.tvalid && in_if.tlast) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      match_q      <= 1'b0;
      bcast_q      <= 1'b0;
      acc_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      match_q      <= match_d;
      bcast_q      <= bcast_d;
      acc_q        <= acc_d;
      drop_q       <= drop_d;
    end
  end
  // Read pipeline: RAM output stage feeding the output register, so a fetch can overlap a consume
  assign out_free = !out_vld_q || out_if.tready;
  assign load     = ram_vld_q && out_free;
  assign fetch    = rd_ptr_q != commit_ptr_q && (!ram_vld_q || out_free);
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= {in_if.tlast && ok, in_if.tdata};
    if (fetch) ram_q <= mem[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q  <= '0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_q + {{AW{1'b0}}, fetch};
      ram_vld_q <= fetch || (ram_vld_q && !load);
      out_vld_q <= load || (out_vld_q && !out_if.tready);
      if (load) out_q <= ram_q;
    end
  end
  assign out_if.tvalid = out_vld_q;
  assign out_if.tdata  = out_q[7:0];
  assign out_if.tlast  = out_q[8];
  assign out_if.tuser  = 1'b0;
endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb_eth_rx_frame_filter: scoreboard bench driving a normal and a promiscuous filter from one MAC stream.
module tb_eth_rx_frame_filter;
  localparam logic [47:0] MAC   = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_99;
  logic clock = 1'b0;
  logic aresetn = 1'b0;
  logic tready = 1'b1;
  logic [15:0] acc_a, drop_a, acc_b, drop_b;
  int errors = 0, checks = 0;
  int exp_acc_a = 0, exp_drop_a = 0, exp_acc_b = 0, exp_drop_b = 0;
  logic [8:0] q_a[$], q_b[$];
  logic [8:0] exp_a, exp_b;
  always #5 clock = ~clock;
  eth_rx_frame_filter_if in_a(), in_b(), out_a(), out_b();
  assign in_b.tdata  = in_a.tdata;
  assign in_b.tvalid = in_a.tvalid;
  assign in_b.tlast  = in_a.tlast;
  assign in_b.tuser  = in_a.tuser;
  assign out_a.tready = tready;
  assign out_b.tready = tready;
  eth_rx_frame_filter #(.MAC_ADDRESS(MAC)) dut_a (
    .clock(clock), .aresetn(aresetn), .in_if(in_a), .out_if(out_a),
    .frames_accepted(acc_a), .frames_dropped(drop_a));
  eth_rx_frame_filter #(.MAC_ADDRESS(MAC), .PROMISCUOUS(1'b1)) dut_b (
    .clock(clock), .aresetn(aresetn), .in_if(in_b), .out_if(out_b),
    .frames_accepted(acc_b), .frames_dropped(drop_b));
  always @(negedge clock) begin
    if (aresetn && out_a.tvalid && out_a.tready) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL out_a extra byte: got %h expected none", {out_a.tlast, out_a.tdata});
      end else begin
        exp_a = q_a.pop_front();
        if ({out_a.tlast, out_a.tdata} !== exp_a) begin
          errors++;
          $display("FAIL out_a byte: got %h expected %h", {out_a.tlast, out_a.tdata}, exp_a);
        end
      end
    end
    if (aresetn && out_b.tvalid && out_b.tready) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL out_b extra byte: got %h expected none", {out_b.tlast, out_b.tdata});
      end else begin
        exp_b = q_b.pop_front();
        if ({out_b.tlast, out_b.tdata} !== exp_b) begin
          errors++;
          $display("FAIL out_b byte: got %h expected %h", {out_b.tlast, out_b.tdata}, exp_b);
        end
      end
    end
  end
  task automatic send_frame(input logic [47:0] da, input int len, input bit err, input bit room);
    logic [7:0] fr[];
    bit good, ok_a;
    fr = new[len];
    for (int i = 0; i < len; i++) fr[i] = i < 6 ? da[47-8*i -: 8] : 8'($urandom);
    good = !err && len >= 60 && len <= 1514 && room;
    ok_a = good && (da == MAC || da == BCAST);
    for (int i = 0; i < len; i++) begin
      if (ok_a) q_a.push_back({i == len - 1, fr[i]});
      if (good) q_b.push_back({i == len - 1, fr[i]});
    end
    exp_acc_a += int'(ok_a);
    exp_drop_a += int'(!ok_a);
    exp_acc_b += int'(good);
    exp_drop_b += int'(!good);
    for (int i = 0; i < len; i++) begin
      in_a.tvalid = 1'b1;
      in_a.tdata  = fr[i];
      in_a.tlast  = i == len - 1;
      in_a.tuser  = err && i == len - 1;
      @(posedge clock);
      #1;
    end
    in_a.tvalid = 1'b0;
    in_a.tlast  = 1'b0;
    in_a.tuser  = 1'b0;
  endtask
  task automatic drain(output bit done);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 6000) begin
      @(posedge clock);
      n++;
    end
    repeat (8) @(posedge clock);
    #1;
    done = q_a.size() == 0 && q_b.size() == 0;
  endtask
  task automatic test_reset;
    #2;
    checks += 6;
    if (out_a.tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %b expected 0", out_a.tvalid); end
    if (out_a.tlast !== 1'b0) begin errors++; $display("FAIL reset tlast: got %b expected 0", out_a.tlast); end
    if (out_a.tdata !== 8'h00) begin errors++; $display("FAIL reset tdata: got %h expected 00", out_a.tdata); end
    if (in_a.tready !== 1'b1) begin errors++; $display("FAIL reset tready: got %b expected 1", in_a.tready); end
    if (acc_a !== 16'd0) begin errors++; $display("FAIL reset accepted: got %0d expected 0", acc_a); end
    if (drop_a !== 16'd0) begin errors++; $display("FAIL reset dropped: got %0d expected 0", drop_a); end
    #10 aresetn = 1'b1;
    @(posedge clock);
    #1;
  endtask
  task automatic test_accept;
    bit done;
    send_frame(MAC, 64, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    checks++;
    if (out_a.tvalid !== 1'b0) begin errors++; $display("FAIL accept latency early: got %b expected 0", out_a.tvalid); end
    @(posedge clock);
    #1;
    checks++;
    if (out_a.tvalid !== 1'b1) begin errors++; $display("FAIL accept latency: got %b expected 1", out_a.tvalid); end
    drain(done);
    checks += 2;
    if (!done) begin errors++; $display("FAIL accept drain: got %0d left expected 0", q_a.size()); end
    if (acc_a !== 16'(exp_acc_a)) begin errors++; $display("FAIL accept count: got %0d expected %0d", acc_a, exp_acc_a); end
  endtask
  task automatic test_address;
    bit done;
    send_frame(BCAST, 60, 1'b0, 1'b1);
    send_frame(FOREIGN, 60, 1'b0, 1'b1);
    send_frame(FOREIGN, 5, 1'b0, 1'b1);
    drain(done);
    checks += 5;
    if (!done) begin errors++; $display("FAIL address drain: got %0d left expected 0", q_a.size() + q_b.size()); end
    if (acc_a !== 16'(exp_acc_a)) begin errors++; $display("FAIL address acc_a: got %0d expected %0d", acc_a, exp_acc_a); end
    if (drop_a !== 16'(exp_drop_a)) begin errors++; $display("FAIL address drop_a: got %0d expected %0d", drop_a, exp_drop_a); end
    if (acc_b !== 16'(exp_acc_b)) begin errors++; $display("FAIL address acc_b: got %0d expected %0d", acc_b, exp_acc_b); end
    if (drop_b !== 16'(exp_drop_b)) begin errors++; $display("FAIL address drop_b: got %0d expected %0d", drop_b, exp_drop_b); end
  endtask
  task automatic test_lengths;
    bit done;
    send_frame(MAC, 100, 1'b1, 1'b1);
    send_frame(MAC, 59, 1'b0, 1'b1);
    send_frame(MAC, 1515, 1'b0, 1'b1);
    send_frame(MAC, 1514, 1'b0, 1'b1);
    send_frame(MAC, 60, 1'b0, 1'b1);
    drain(done);
    checks += 3;
    if (!done) begin errors++; $display("FAIL lengths drain: got %0d left expected 0", q_a.size() + q_b.size()); end
    if (acc_a !== 16'(exp_acc_a)) begin errors++; $display("FAIL lengths acc_a: got %0d expected %0d", acc_a, exp_acc_a); end
    if (drop_b !== 16'(exp_drop_b)) begin errors++; $display("FAIL lengths drop_b: got %0d expected %0d", drop_b, exp_drop_b); end
  endtask
  task automatic test_overflow;
    bit done;
    tready = 1'b0;
    send_frame(MAC, 1500, 1'b0, 1'b1);
    send_frame(MAC, 1000, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checks += 3;
    if (drop_a !== 16'(exp_drop_a)) begin errors++; $display("FAIL overflow drop_a: got %0d expected %0d", drop_a, exp_drop_a); end
    if (out_a.tvalid !== 1'b1) begin errors++; $display("FAIL overflow held tvalid: got %b expected 1", out_a.tvalid); end
    if ({out_a.tlast, out_a.tdata} !== q_a[0]) begin errors++; $display("FAIL overflow held data: got %h expected %h", {out_a.tlast, out_a.tdata}, q_a[0]); end
    tready = 1'b1;
    drain(done);
    checks += 2;
    if (!done) begin errors++; $display("FAIL overflow drain: got %0d left expected 0", q_a.size() + q_b.size()); end
    if (acc_a !== 16'(exp_acc_a)) begin errors++; $display("FAIL overflow acc_a: got %0d expected %0d", acc_a, exp_acc_a); end
  endtask
  task automatic test_back_to_back;
    bit done, sent;
    int base = exp_acc_a;
    sent = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) send_frame(MAC, 100, 1'b0, 1'b1);
        sent = 1'b1;
      end
      begin
        while (!sent) begin
          @(posedge clock);
          #1;
          tready = $urandom_range(0, 3) != 0;
        end
      end
    join
    tready = 1'b1;
    drain(done);
    checks += 3;
    if (!done) begin errors++; $display("FAIL b2b drain: got %0d left expected 0", q_a.size() + q_b.size()); end
    if (acc_a !== 16'(base + 40)) begin errors++; $display("FAIL b2b acc_a: got %0d expected %0d", acc_a, base + 40); end
    if (acc_b !== 16'(exp_acc_b)) begin errors++; $display("FAIL b2b acc_b: got %0d expected %0d", acc_b, exp_acc_b); end
  endtask
  task automatic test_mid_reset;
    bit done;
    send_frame(MAC, 200, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      in_a.tvalid = 1'b1;
      in_a.tdata  = 8'(i);
      in_a.tlast  = 1'b0;
      @(posedge clock);
      #1;
    end
    checks++;
    if (out_a.tvalid !== 1'b1) begin errors++; $display("FAIL midreset active: got %b expected 1", out_a.tvalid); end
    #2 aresetn = 1'b0;
    in_a.tvalid = 1'b0;
    #1;
    checks += 4;
    if (out_a.tvalid !== 1'b0) begin errors++; $display("FAIL midreset tvalid_a: got %b expected 0", out_a.tvalid); end
    if (out_b.tvalid !== 1'b0) begin errors++; $display("FAIL midreset tvalid_b: got %b expected 0", out_b.tvalid); end
    if (acc_a !== 16'd0) begin errors++; $display("FAIL midreset acc_a: got %0d expected 0", acc_a); end
    if (drop_a !== 16'd0) begin errors++; $display("FAIL midreset drop_a: got %0d expected 0", drop_a); end
    q_a.delete();
    q_b.delete();
    exp_acc_a = 0; exp_drop_a = 0; exp_acc_b = 0; exp_drop_b = 0;
    #20 aresetn = 1'b1;
    @(posedge clock);
    #1;
    send_frame(MAC, 80, 1'b0, 1'b1);
    drain(done);
    checks += 2;
    if (!done) begin errors++; $display("FAIL midreset drain: got %0d left expected 0", q_a.size() + q_b.size()); end
    if (acc_a !== 16'd1) begin errors++; $display("FAIL midreset recount: got %0d expected 1", acc_a); end
  endtask
  initial begin
    in_a.tvalid = 1'b0;
    in_a.tdata  = 8'h00;
    in_a.tlast  = 1'b0;
    in_a.tuser  = 1'b0;
    test_reset();
    test_accept();
    test_address();
    test_lengths();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
